// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: owns the shared memory bus between the CPU and the MMU.
// A CPU write to the DMA register starts a DMA_LEN-byte copy from page
// {src_hi,8'h00} into OAM. Each byte takes a read cycle and then a write cycle.
// While the copy runs, CPU writes are dropped and CPU reads return 8'hFF.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int unsigned DMA_LEN      = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RD    = 2'd2,
        S_WR    = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic       dma_done_q, dma_done_d;
    logic       cpu_owned_q;

    // Source pages at or above 0xE0 are echo RAM; fold them down to the WRAM they mirror.
    function automatic logic [7:0] fold_src_page(input logic [7:0] page);
        logic [7:0] folded;
        if (page < 8'hE0) begin
            folded = page;
        end else begin
            folded = page - 8'h20;
        end
        return folded;
    endfunction

    // State, index, source page and completion pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'd0;
            src_hi_q   <= 8'd0;
            dma_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            src_hi_q   <= src_hi_d;
            dma_done_q <= dma_done_d;
        end
    end

    // Record whether the CPU owned the bus, so that the next cycle's read data can be qualified.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_owned_q <= 1'b1;
        end else begin
            cpu_owned_q <= (state_q == S_IDLE);
        end
    end

    // Next-state logic and bus mux. Outside IDLE the bus is driven only from internal state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        src_hi_d   = src_hi_q;
        dma_done_d = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    src_hi_d = fold_src_page(cpu_wdata);
                    state_d  = S_START;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_START: begin
                mem_addr = {src_hi_q, 8'h00};
                idx_d    = 8'd0;
                state_d  = S_RD;
            end
            S_RD: begin
                mem_addr = {src_hi_q, idx_q};
                state_d  = S_WR;
            end
            S_WR: begin
                // mem_rdata holds the byte addressed by the preceding RD cycle.
                mem_addr  = OAM_BASE + {8'h00, idx_q};
                mem_wdata = mem_rdata;
                mem_we    = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d      = 8'd0;
                    dma_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    idx_d      = idx_q + 8'd1;
                    state_d    = S_RD;
                end
            end
            default: begin
                idx_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign dma_active = (state_q != S_IDLE);
    assign dma_done   = dma_done_q;
    assign cpu_rdata  = cpu_owned_q ? mem_rdata : 8'hFF;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter. It uses a byte-wide synchronous-read memory model
// as the MMU, runs table-driven pass-through vectors and source-page transfers, and ends
// with a hand-written asynchronous-reset abort sequence.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        dma_active;
    logic        dma_done;

    logic [7:0]  mem [0:65535];

    int n_vec;
    int n_err;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active),
        .dma_done   (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MMU model: synchronous read with read-before-write.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        rd_chk;
        logic [7:0]  exp_rdata;
    } pt_vec_t;

    typedef struct {
        logic [7:0] trig;
        logic [7:0] src;
    } xfer_vec_t;

    pt_vec_t   pv [9];
    xfer_vec_t xv [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        step();
        cpu_we    = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i, input logic [7:0] k);
        return (8'(i) ^ 8'h5A) + k;
    endfunction

    task automatic prep(input logic [7:0] src, input logic [7:0] k);
        for (int i = 0; i < 160; i++) cpu_wr(16'hFE00 + 16'(i), 8'hEE);
        for (int i = 0; i < 160; i++) cpu_wr({src, 8'(i)}, pat(i, k));
        cpu_wr(16'hC000, 8'h33);
    endtask

    // One full transfer, with CPU writes to C000 and a re-trigger attempt at cycle 50.
    task automatic run_xfer(input logic [7:0] trig, input logic [7:0] src, input logic [7:0] k);
        int idx;
        prep(src, k);
        cpu_addr  = 16'hFF46;
        cpu_wdata = trig;
        cpu_we    = 1'b1;
        #1;
        chk("trig_pass_addr", mem_addr, 16'hFF46);
        chk("trig_pass_we", {15'd0, mem_we}, 16'd1);
        for (int c = 1; c <= 324; c++) begin
            step();
            cpu_we    = 1'b0;
            cpu_addr  = 16'hC000;
            cpu_wdata = 8'h00;
            if (c >= 10 && c <= 20) begin
                cpu_we    = 1'b1;
                cpu_wdata = 8'h77;
            end
            if (c == 50) begin
                cpu_we    = 1'b1;
                cpu_addr  = 16'hFF46;
                cpu_wdata = trig ^ 8'h10;
            end
            #1;
            chk($sformatf("active_c%0d", c), {15'd0, dma_active}, {15'd0, (c <= 321)});
            chk($sformatf("done_c%0d", c), {15'd0, dma_done}, {15'd0, (c == 322)});
            if (c >= 2 && c <= 322) chk($sformatf("rdata_ff_c%0d", c), {8'd0, cpu_rdata}, 16'h00FF);
            if (c == 323) chk("rdata_idle", {8'd0, cpu_rdata}, 16'h0033);
            if (c == 1) begin
                chk("start_addr", mem_addr, {src, 8'h00});
                chk("start_we", {15'd0, mem_we}, 16'd0);
            end else if (c <= 321) begin
                if ((c % 2) == 0) begin
                    idx = (c - 2) / 2;
                    chk($sformatf("rd_addr_c%0d", c), mem_addr, {src, 8'(idx)});
                    chk($sformatf("rd_we_c%0d", c), {15'd0, mem_we}, 16'd0);
                end else begin
                    idx = (c - 3) / 2;
                    chk($sformatf("wr_addr_c%0d", c), mem_addr, 16'hFE00 + 16'(idx));
                    chk($sformatf("wr_we_c%0d", c), {15'd0, mem_we}, 16'd1);
                    chk($sformatf("wr_data_c%0d", c), {8'd0, mem_wdata}, {8'd0, pat(idx, k)});
                end
            end else begin
                chk($sformatf("idle_addr_c%0d", c), mem_addr, 16'hC000);
                chk($sformatf("idle_we_c%0d", c), {15'd0, mem_we}, 16'd0);
            end
        end
        for (int i = 0; i < 160; i++)
            chk($sformatf("oam_%0d", i), {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, pat(i, k)});
        chk("c000_kept", {8'd0, mem[16'hC000]}, 16'h0033);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;

        pv[0] = '{16'hC010, 8'h3C, 1'b1, 1'b0, 8'h00};
        pv[1] = '{16'hC011, 8'hA5, 1'b1, 1'b0, 8'h00};
        pv[2] = '{16'hC010, 8'h00, 1'b0, 1'b0, 8'h00};
        pv[3] = '{16'hC011, 8'h00, 1'b0, 1'b1, 8'h3C};
        pv[4] = '{16'h8000, 8'h99, 1'b0, 1'b1, 8'hA5};
        pv[5] = '{16'hFF45, 8'h12, 1'b1, 1'b0, 8'h00};
        pv[6] = '{16'hFF47, 8'h34, 1'b1, 1'b0, 8'h00};
        pv[7] = '{16'hFF46, 8'hC1, 1'b0, 1'b0, 8'h00};
        pv[8] = '{16'h1234, 8'h00, 1'b0, 1'b0, 8'h00};

        xv[0] = '{8'hC1, 8'hC1};
        xv[1] = '{8'hF2, 8'hD2};
        xv[2] = '{8'hE5, 8'hC5};
        xv[3] = '{8'hDF, 8'hDF};
        xv[4] = '{8'h00, 8'h00};
        xv[5] = '{8'hFD, 8'hDD};

        #12;
        chk("rst_active", {15'd0, dma_active}, 16'd0);
        chk("rst_done", {15'd0, dma_done}, 16'd0);
        chk("rst_pass_addr", mem_addr, 16'h0000);
        rst = 1'b1;
        step();

        for (int v = 0; v < 9; v++) begin
            cpu_addr  = pv[v].addr;
            cpu_wdata = pv[v].wdata;
            cpu_we    = pv[v].we;
            #1;
            chk($sformatf("pv%0d_addr", v), mem_addr, pv[v].addr);
            chk($sformatf("pv%0d_wdata", v), {8'd0, mem_wdata}, {8'd0, pv[v].wdata});
            chk($sformatf("pv%0d_we", v), {15'd0, mem_we}, {15'd0, pv[v].we});
            chk($sformatf("pv%0d_active", v), {15'd0, dma_active}, 16'd0);
            if (pv[v].rd_chk) chk($sformatf("pv%0d_rdata", v), {8'd0, cpu_rdata}, {8'd0, pv[v].exp_rdata});
            step();
        end
        cpu_we = 1'b0;
        step();
        chk("no_false_trig", {15'd0, dma_active}, 16'd0);

        for (int x = 0; x < 6; x++) run_xfer(xv[x].trig, xv[x].src, 8'(x * 17));

        // Asynchronous reset while the DMA is writing idx 40.
        prep(8'hC1, 8'h40);
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'hC1;
        cpu_we    = 1'b1;
        for (int c = 1; c <= 83; c++) begin
            step();
            cpu_we   = 1'b0;
            cpu_addr = 16'hC000;
        end
        #1;
        chk("abort_wr_addr", mem_addr, 16'hFE28);
        chk("abort_wr_we", {15'd0, mem_we}, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_active", {15'd0, dma_active}, 16'd0);
        chk("abort_done", {15'd0, dma_done}, 16'd0);
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h55;
        cpu_we    = 1'b0;
        #1;
        chk("abort_pass_addr", mem_addr, 16'h1234);
        chk("abort_pass_wdata", {8'd0, mem_wdata}, 16'h0055);
        chk("abort_pass_we", {15'd0, mem_we}, 16'd0);
        #2;
        rst = 1'b1;
        step();
        step();
        chk("abort_idle", {15'd0, dma_active}, 16'd0);
        for (int i = 0; i < 160; i++) begin
            if (i < 40) chk($sformatf("abort_oam_%0d", i), {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, pat(i, 8'h40)});
            else        chk($sformatf("abort_oam_%0d", i), {8'd0, mem[16'hFE00 + 16'(i)]}, 16'h00EE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
